// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of every signal the arbiter exchanges with its
// requesters, the external ALU and the response consumer.
//   master modport : the environment side (drives requests, alu_result, rsp_ready)
//   slave modport  : the arbiter side
// Handshake rule for both the request ports and the response port: a transfer
// happens in a cycle where valid && ready are both 1 at the rising edge;
// valid and its payload must stay stable until that transfer happens.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_s0;
  logic             alu_s1;
  logic             alu_s2;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_s0, alu_s1, alu_s2,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_s0, alu_s1, alu_s2,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one external combinational
// ALU between two requesters. One operation is in flight at a time:
// IDLE (arbitrate/grant) -> EXEC (ALU evaluates registered inputs) ->
// RESP (hold tagged response until rsp_ready).
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       alu_arbiter_if.slave: request ports, ALU operand/select outputs,
//             ALU result input, tagged response port
//   dbg_state current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//   dbg_prio  round-robin pointer (requester preferred when both are valid)
// Optional feature: define ALU_ARB_OPCHK_EN to reject op 3'b111; such an
// operation is granted but leaves the ALU registers untouched and answers
// with rsp_err=1, rsp_result=0. Without it op 3'b111 goes to the ALU and
// rsp_err is constant 0.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [1:0]   dbg_state,
  output logic         dbg_prio
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

`ifdef ALU_ARB_OPCHK_EN
  logic             op_bad_q;
`endif

  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        // prio_q only matters when both requesters are valid.
        if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
          grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant0 | grant1;

  // Gated with rst_n so that no ready is seen while reset is held, even
  // though the state register already reads IDLE.
  assign bus.req0_ready = grant0 & rst_n;
  assign bus.req1_ready = grant1 & rst_n;

  assign sel_op = grant1 ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant1 ? bus.req1_b  : bus.req0_b;

  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prio_q         <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_s0     <= 1'b0;
      bus.alu_s1     <= 1'b0;
      bus.alu_s2     <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
`ifdef ALU_ARB_OPCHK_EN
      bus.rsp_err    <= 1'b0;
      op_bad_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        // Pointer moves to the requester that lost (or was absent).
        prio_q     <= grant0;
        bus.rsp_id <= grant1;
`ifdef ALU_ARB_OPCHK_EN
        op_bad_q <= (sel_op == 3'b111);
        if (sel_op != 3'b111) begin
          bus.alu_a  <= sel_a;
          bus.alu_b  <= sel_b;
          bus.alu_s0 <= sel_op[2];
          bus.alu_s1 <= sel_op[1];
          bus.alu_s2 <= sel_op[0];
        end
`else
        bus.alu_a  <= sel_a;
        bus.alu_b  <= sel_b;
        bus.alu_s0 <= sel_op[2];
        bus.alu_s1 <= sel_op[1];
        bus.alu_s2 <= sel_op[0];
`endif
      end
      if (state_q == EXEC) begin
        bus.rsp_valid <= 1'b1;
`ifdef ALU_ARB_OPCHK_EN
        bus.rsp_result <= op_bad_q ? '0 : bus.alu_result;
        bus.rsp_err    <= op_bad_q;
`else
        bus.rsp_result <= bus.alu_result;
`endif
      end
      if (state_q == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

`ifndef ALU_ARB_OPCHK_EN
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. A behavioural ALU
// drives alu_result from the DUT's ALU outputs; expected responses come from
// a grant model (round-robin pointer rule) and the same ALU function applied
// to the operation each requester presented.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int EW = W + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  logic       dbg_prio;

  alu_arbiter_if #(.WIDTH(W)) bus();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state),
    .dbg_prio (dbg_prio)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return b;
    endcase
  endfunction

  assign bus.alu_result = alu_fn({bus.alu_s0, bus.alu_s1, bus.alu_s2}, bus.alu_a, bus.alu_b);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int m_prio   = 0;
  logic [EW-1:0] exp_q[$];

  // Grant rule: a lone requester wins; with both valid the pointer decides;
  // the pointer then names the requester that did not win.
  function automatic int model_grant(input bit v0, input bit v1);
    int g;
    g = (v0 && v1) ? m_prio : (v0 ? 0 : 1);
    m_prio = 1 - g;
    return g;
  endfunction

  function automatic logic [W-1:0] exp_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ALU_ARB_OPCHK_EN
    if (op == 3'b111) return '0;
`endif
    return alu_fn(op, a, b);
  endfunction

  function automatic logic exp_err(input logic [2:0] op);
`ifdef ALU_ARB_OPCHK_EN
    return (op == 3'b111);
`else
    return (op == 3'b111) && 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input bit v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Presents a request and holds it until ready; returns cycles waited
  // (-1 on timeout). Returns just after the accepting edge.
  task automatic drive_req(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    bit seen;
    seen = 1'b0;
    waited = 0;
    set_req(id, 1'b1, op, a, b);
    while (!seen && waited < 50) begin
      #1;
      seen = (id == 0) ? bus.req0_ready : bus.req1_ready;
      if (!seen) begin
        tick();
        waited++;
      end
    end
    if (!seen) waited = -1;
    tick();
    if (id == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  // Raises rsp_ready and waits for a response; lat counts edges from entry
  // (-1 on timeout). Returns just after the edge that completes the transfer.
  task automatic collect_rsp(output int lat, output logic id, output logic [W-1:0] res, output logic err);
    bus.rsp_ready = 1'b1;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!bus.rsp_valid) lat = -1;
    id = bus.rsp_id;
    res = bus.rsp_result;
    err = bus.rsp_err;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b1, 3'd0, '0, '0);
    set_req(1, 1'b1, 3'd0, '0, '0);
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); else n_pass++;
    n_checks++; if ({bus.alu_a, bus.alu_b, bus.alu_s0, bus.alu_s1, bus.alu_s2} !== '0) $display("FAIL reset_alu got=%h/%h exp=0", bus.alu_a, bus.alu_b); else n_pass++;
    n_checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result} !== '0) $display("FAIL reset_rsp got v=%b id=%b err=%b res=%h exp=0", bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result); else n_pass++;
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
    tick();
    rst_n = 1'b1;
    m_prio = 0;
    tick();
  endtask

  task automatic test_single();
    int w, lat, g;
    logic id, err;
    logic [W-1:0] res;
    drive_req(0, 3'b000, 32'h5840, 32'h6230, w);
    g = model_grant(1, 0);
    n_checks++; if (w !== 0) $display("FAIL single_wait got=%0d exp=0", w); else n_pass++;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL single_ready_pulse got=%b exp=0", bus.req0_ready); else n_pass++;
    n_checks++; if ({bus.alu_a, bus.alu_b} !== {32'h5840, 32'h6230}) $display("FAIL single_operands got=%h/%h exp=5840/6230", bus.alu_a, bus.alu_b); else n_pass++;
    n_checks++; if ({bus.alu_s0, bus.alu_s1, bus.alu_s2} !== 3'b000) $display("FAIL single_sel got=%b exp=000", {bus.alu_s0, bus.alu_s1, bus.alu_s2}); else n_pass++;
    collect_rsp(lat, id, res, err);
    n_checks++; if (lat !== 1) $display("FAIL single_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if ({id, err} !== {1'(g), 1'b0}) $display("FAIL single_id_err got=%b%b exp=%0d0", id, err, g); else n_pass++;
    n_checks++; if (res !== exp_result(3'b000, 32'h5840, 32'h6230)) $display("FAIL single_result got=%h exp=%h", res, exp_result(3'b000, 32'h5840, 32'h6230)); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_valid_drop got=%b exp=0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_op_sweep();
    int w, lat, g;
    logic id, err;
    logic [W-1:0] res;
    for (int op = 0; op < 7; op++) begin
      drive_req(1, 3'(op), 32'h5840, 32'h6230, w);
      g = model_grant(0, 1);
      n_checks++; if ({bus.alu_s0, bus.alu_s1, bus.alu_s2} !== 3'(op)) $display("FAIL sweep_sel op=%0d got=%b", op, {bus.alu_s0, bus.alu_s1, bus.alu_s2}); else n_pass++;
      collect_rsp(lat, id, res, err);
      n_checks++; if ({id, err, lat} !== {1'(g), 1'b0, 32'd1}) $display("FAIL sweep_tag op=%0d got id=%b err=%b lat=%0d exp id=%0d err=0 lat=1", op, id, err, lat, g); else n_pass++;
      n_checks++; if (res !== exp_result(3'(op), 32'h5840, 32'h6230)) $display("FAIL sweep_result op=%0d got=%h exp=%h", op, res, exp_result(3'(op), 32'h5840, 32'h6230)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   op[2];
    logic [W-1:0] a[2], b[2];
    logic [EW-1:0] e;
    int last, g_cnt, eg;
    bit g0, g1;
    last = -1;
    g_cnt = 0;
    exp_q.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op[i] = 3'($urandom_range(0, 6)); a[i] = $urandom; b[i] = $urandom;
      set_req(i, 1'b1, op[i], a[i], b[i]);
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      if (g0 || g1) begin
        eg = model_grant(1, 1);
        n_checks++; if ({g0, g1} !== ((eg == 0) ? 2'b10 : 2'b01)) $display("FAIL b2b_grant cyc=%0d got=%b%b exp_id=%0d", cyc, g0, g1, eg); else n_pass++;
        if (last >= 0) begin
          n_checks++; if (cyc - last !== 3) $display("FAIL b2b_spacing got=%0d exp=3", cyc - last); else n_pass++;
        end
        last = cyc;
        g_cnt++;
        exp_q.push_back({1'(eg), exp_result(op[eg], a[eg], b[eg])});
      end
      if (bus.rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if ({bus.rsp_id, bus.rsp_result} !== e || bus.rsp_err !== 1'b0) $display("FAIL b2b_rsp got id=%b res=%h err=%b exp=%h", bus.rsp_id, bus.rsp_result, bus.rsp_err, e); else n_pass++;
      end
      tick();
      if (g0 || g1) begin
        eg = g1 ? 1 : 0;
        op[eg] = 3'($urandom_range(0, 6)); a[eg] = $urandom; b[eg] = $urandom;
        set_req(eg, 1'b1, op[eg], a[eg], b[eg]);
      end
    end
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        n_checks++; if ({bus.rsp_id, bus.rsp_result} !== e) $display("FAIL b2b_drain got id=%b res=%h exp=%h", bus.rsp_id, bus.rsp_result, e); else n_pass++;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0 || g_cnt < 9) $display("FAIL b2b_count got grants=%0d pending=%0d exp grants>=9 pending=0", g_cnt, exp_q.size()); else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    int w, lat, g;
    logic id, err;
    logic [W-1:0] res, ea, eb, exp_r;
    ea = $urandom; eb = $urandom;
    bus.rsp_ready = 1'b0;
    drive_req(0, 3'd4, ea, eb, w);
    g = model_grant(1, 0);
    exp_r = exp_result(3'd4, ea, eb);
    set_req(1, 1'b1, 3'd3, eb, ea);
    for (int k = 0; k < 5 && !bus.rsp_valid; k++) tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.req1_ready} !== {1'b1, 1'(g), 1'b0, exp_r, 1'b0})
        $display("FAIL stall_hold i=%0d got v=%b id=%b err=%b res=%h rdy1=%b exp res=%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.req1_ready, exp_r); else n_pass++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b0) $display("FAIL stall_release_ready got=%b exp=0", bus.req1_ready); else n_pass++;
    tick();
    #1;
    n_checks++; if ({bus.req1_ready, bus.rsp_valid} !== 2'b10) $display("FAIL stall_regrant got rdy1=%b v=%b exp 1/0", bus.req1_ready, bus.rsp_valid); else n_pass++;
    g = model_grant(0, 1);
    tick();
    bus.req1_valid = 1'b0;
    collect_rsp(lat, id, res, err);
    n_checks++; if ({id, res, lat} !== {1'(g), exp_result(3'd3, eb, ea), 32'd1}) $display("FAIL stall_next got id=%b res=%h lat=%0d", id, res, lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w, lat, g;
    logic id, err;
    logic [W-1:0] res, na, nb;
    drive_req(0, 3'd1, 32'h1234, 32'h0034, w);
    g = model_grant(1, 0);
    na = $urandom; nb = $urandom;
    set_req(0, 1'b1, 3'd2, na, nb);
    set_req(1, 1'b1, 3'd0, nb, na);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_result, bus.alu_a, bus.alu_b, bus.alu_s0, bus.alu_s1, bus.alu_s2} !== '0)
      $display("FAIL rstmid_outputs got rdy=%b%b v=%b res=%h a=%h", bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_result, bus.alu_a); else n_pass++;
    m_prio = 0;
    tick();
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rstmid_no_rsp got=%b exp=0", bus.rsp_valid); else n_pass++;
    rst_n = 1'b1;
    #1;
    g = model_grant(1, 1);
    n_checks++; if ({bus.req0_ready, bus.req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) $display("FAIL rstmid_first_grant got=%b%b exp_id=%0d", bus.req0_ready, bus.req1_ready, g); else n_pass++;
    tick();
    bus.req0_valid = 1'b0;
    collect_rsp(lat, id, res, err);
    n_checks++; if ({id, res} !== {1'(g), exp_result(3'd2, na, nb)}) $display("FAIL rstmid_rsp0 got id=%b res=%h exp id=%0d res=%h", id, res, g, exp_result(3'd2, na, nb)); else n_pass++;
    drive_req(1, 3'd0, nb, na, w);
    g = model_grant(0, 1);
    collect_rsp(lat, id, res, err);
    n_checks++; if ({id, res, w} !== {1'(g), exp_result(3'd0, nb, na), 32'd0}) $display("FAIL rstmid_rsp1 got id=%b res=%h wait=%0d", id, res, w); else n_pass++;
  endtask

  task automatic test_opchk();
    int w, lat, g;
    logic id, err;
    logic [W-1:0] res;
    drive_req(0, 3'b010, 32'hf0f0_1234, 32'h0ff0_ffff, w);
    g = model_grant(1, 0);
    collect_rsp(lat, id, res, err);
    drive_req(0, 3'b111, 32'h1111_2222, 32'h3333_4444, w);
    g = model_grant(1, 0);
`ifdef ALU_ARB_OPCHK_EN
    n_checks++; if ({bus.alu_s0, bus.alu_s1, bus.alu_s2, bus.alu_a} !== {3'b010, 32'hf0f0_1234}) $display("FAIL opchk_alu_hold got sel=%b a=%h exp 010/f0f01234", {bus.alu_s0, bus.alu_s1, bus.alu_s2}, bus.alu_a); else n_pass++;
`else
    n_checks++; if ({bus.alu_s0, bus.alu_s1, bus.alu_s2, bus.alu_a} !== {3'b111, 32'h1111_2222}) $display("FAIL opchk_alu_fwd got sel=%b a=%h exp 111/11112222", {bus.alu_s0, bus.alu_s1, bus.alu_s2}, bus.alu_a); else n_pass++;
`endif
    collect_rsp(lat, id, res, err);
    n_checks++; if ({id, err, res, lat} !== {1'(g), exp_err(3'b111), exp_result(3'b111, 32'h1111_2222, 32'h3333_4444), 32'd1})
      $display("FAIL opchk_rsp got id=%b err=%b res=%h lat=%0d exp err=%b res=%h", id, err, res, lat, exp_err(3'b111), exp_result(3'b111, 32'h1111_2222, 32'h3333_4444)); else n_pass++;
  endtask

  task automatic test_random_bp();
    int w, lat, g, rid;
    logic id, err;
    logic [2:0] op;
    logic [W-1:0] res, a, b;
    for (int i = 0; i < 10; i++) begin
      rid = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      bus.rsp_ready = 1'b0;
      drive_req(rid, op, a, b, w);
      g = model_grant(rid == 0, rid == 1);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) tick();
      collect_rsp(lat, id, res, err);
      n_checks++; if ({id, err, res} !== {1'(g), exp_err(op), exp_result(op, a, b)} || lat < 0)
        $display("FAIL rand_rsp i=%0d got id=%b err=%b res=%h lat=%0d exp id=%0d res=%h", i, id, err, res, lat, g, exp_result(op, a, b)); else n_pass++;
    end
  endtask

  initial begin
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_op_sweep();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_opchk();
    test_random_bp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
